// File: rtl/idct_pkg.sv
// Shared widths, fixed-point constants and the IDCT basis table for the 8-point
// serial inverse DCT.
package idct_pkg;

  localparam int BWI_DEF    = 12;
  localparam int BWO_DEF    = 10;
  localparam int CW_DEF     = 9;
  localparam int ACCW_DEF   = BWI_DEF + 12;
  localparam int N_PTS      = 8;
  localparam int FRAC_SHIFT = 8;
  localparam int ROUND_OFS  = 128;
  localparam int DC_MAG     = 91;

  typedef logic [2:0] idx_t;

  // round(128*cos(m*pi/16)) for m = 0..8
  function automatic int cos_mag(input int m);
    int r;
    case (m)
      0:       r = 128;
      1:       r = 126;
      2:       r = 118;
      3:       r = 106;
      4:       r = 91;
      5:       r = 71;
      6:       r = 49;
      7:       r = 25;
      default: r = 0;
    endcase
    return r;
  endfunction

  // C[n][k]: fold (2n+1)k into the first quadrant of the cosine and track the sign
  function automatic int c_coef(input int n, input int k);
    int m;
    int r;
    if (k == 0) begin
      r = DC_MAG;
    end else begin
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) r = -cos_mag(16 - m);
      else       r = cos_mag(m);
    end
    return r;
  endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One output lane of the serial IDCT: multiplies each coefficient by its basis
// constant, accumulates, and latches the rounded/saturated sample at frame close.
module idct_mac_lane
  import idct_pkg::*;
#(
  parameter int ROW  = 0,
  parameter int BWi  = BWI_DEF,
  parameter int BWo  = BWO_DEF,
  parameter int CW   = CW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  idx_t                   k_idx,
  input  logic signed [BWi-1:0]  x,
  output logic signed [BWo-1:0]  y
);

  localparam int PW = CW + BWi;
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((2 ** (BWo - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-(2 ** (BWo - 1)));

  logic signed [CW-1:0]   coef;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_base;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] rounded;
  logic signed [BWo-1:0]  sat_y;
  logic                   first_beat;
  logic                   last_beat;

  assign first_beat = (k_idx == idx_t'(0));
  assign last_beat  = (k_idx == idx_t'(N_PTS - 1));

  always_comb begin
    coef = CW'(c_coef(ROW, int'(k_idx)));
  end

  assign prod     = coef * x;
  assign prod_ext = {{(ACCW - PW){prod[PW-1]}}, prod};
  // A k=0 beat restarts the sum, which is also how a mid-frame sync drops the partial frame
  assign acc_base = first_beat ? '0 : acc;
  assign sum      = acc_base + prod_ext;
  assign rounded  = (sum + ACCW'(ROUND_OFS)) >>> FRAC_SHIFT;

  always_comb begin
    if (rounded > SAT_HI)      sat_y = BWo'(SAT_HI);
    else if (rounded < SAT_LO) sat_y = BWo'(SAT_LO);
    else                       sat_y = BWo'(rounded);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      y   <= '0;
    end else if (enb) begin
      acc <= sum;
      if (last_beat) y <= sat_y;
    end
  end

endmodule

// File: rtl/idct_1d_serial.sv
// 8-point 1-D inverse DCT, serial in / serial out: eight MAC lanes fed in
// parallel, results streamed out one sample per enabled beat a frame later.
module idct_1d_serial
  import idct_pkg::*;
#(
  parameter int BWi  = BWI_DEF,
  parameter int BWo  = BWO_DEF,
  parameter int CW   = CW_DEF,
  parameter int ACCW = BWi + 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic                   sync,
  input  logic signed [BWi-1:0]  idct_in,
  output logic signed [BWo-1:0]  idct_out,
  output logic                   idct_valid,
  output logic                   idct_sof
);

  idx_t                  in_cnt;
  idx_t                  out_cnt;
  idx_t                  k_idx;
  logic                  frame_close;
  logic                  valid_q;
  logic signed [BWo-1:0] lane_y [N_PTS];

  // sync forces the current beat to be X[0] regardless of where the counter was
  assign k_idx       = sync ? idx_t'(0) : in_cnt;
  assign frame_close = (k_idx == idx_t'(N_PTS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      valid_q <= 1'b0;
    end else if (enb) begin
      in_cnt  <= k_idx + idx_t'(1);
      out_cnt <= frame_close ? idx_t'(0) : out_cnt + idx_t'(1);
      if (frame_close) valid_q <= 1'b1;
    end
  end

  for (genvar n = 0; n < N_PTS; n++) begin : g_lane
    idct_mac_lane #(
      .ROW  (n),
      .BWi  (BWi),
      .BWo  (BWo),
      .CW   (CW),
      .ACCW (ACCW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .enb   (enb),
      .k_idx (k_idx),
      .x     (idct_in),
      .y     (lane_y[n])
    );
  end

  assign idct_out   = lane_y[out_cnt];
  assign idct_valid = valid_q;
  assign idct_sof   = valid_q && (out_cnt == idx_t'(0));

endmodule

// File: tb/tb_idct_1d_serial.sv
// Directed bench for idct_1d_serial: a real-valued reference IDCT fills a
// scoreboard at every frame close, drained as samples stream out.
module tb_idct_1d_serial;

  localparam int  BWI = 12;
  localparam int  BWO = 10;
  localparam real PI  = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enb;
  logic                  sync;
  logic signed [BWI-1:0] idct_in;
  logic signed [BWO-1:0] idct_out;
  logic                  idct_valid;
  logic                  idct_sof;

  idct_1d_serial #(.BWi(BWI), .BWo(BWO)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .sync       (sync),
    .idct_in    (idct_in),
    .idct_out   (idct_out),
    .idct_valid (idct_valid),
    .idct_sof   (idct_sof)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int idx; } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_valid = 1'b0;
  bit   last_popped = 1'b0;
  int   held = 0;

  function automatic int ref_coef(input int n, input int k);
    real a;
    real v;
    a = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 128.0 * a * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int model_y(input int xs[8], input int n);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(ref_coef(n, k)) * longint'(xs[k]);
    s = (s + 128) >>> 8;
    if (s > 511)       s = 511;
    else if (s < -512) s = -512;
    return int'(s);
  endfunction

  task automatic check_output(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input int x, input bit s, input bit e);
    idct_in = BWI'(x);
    sync    = s;
    enb     = e;
    @(posedge clk);
    #1;
  endtask

  // after an enabled beat: valid always, sample/sof whenever a frame is streaming
  task automatic check_beat();
    exp_t e;
    check_output("valid", int'(idct_valid), int'(exp_valid));
    last_popped = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output($sformatf("y%0d", e.idx), int'(idct_out), e.y);
      check_output($sformatf("sof@y%0d", e.idx), int'(idct_sof), (e.idx == 0) ? 1 : 0);
      held        = e.y;
      last_popped = 1'b1;
    end
  endtask

  task automatic push_frame(input int xs[8]);
    exp_t e;
    for (int n = 0; n < 8; n++) begin
      e.y   = model_y(xs, n);
      e.idx = n;
      exp_q.push_back(e);
    end
    exp_valid = 1'b1;
  endtask

  // sync on X[0]; optional enb-low gap (with junk on the inputs) before every odd beat
  task automatic send_frame(input int xs[8], input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps && (k % 2 == 1)) begin
        apply_stimulus(int'($urandom_range(4095)) - 2048, 1'b1, 1'b0);
        check_output("hold_valid", int'(idct_valid), int'(exp_valid));
        if (last_popped) check_output("hold_out", int'(idct_out), held);
      end
      apply_stimulus(xs[k], k == 0, 1'b1);
      if (k == 7) push_frame(xs);
      check_beat();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(int'($urandom_range(4095)) - 2048, 1'b0, 1'b1);
      check_beat();
    end
  endtask

  initial begin
    int xs[8];
    int ra[8];

    rst     = 1'b1;
    enb     = 1'b1;
    sync    = 1'b1;
    idct_in = BWI'(100);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_out", int'(idct_out), 0);
    check_output("rst_valid", int'(idct_valid), 0);
    check_output("rst_sof", int'(idct_sof), 0);
    rst = 1'b0;

    $display("[TB] DC-only frame");
    xs = '{256, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xs, 1'b0);
    drain();

    $display("[TB] first AC basis");
    xs = '{0, 256, 0, 0, 0, 0, 0, 0};
    send_frame(xs, 1'b0);
    drain();

    $display("[TB] saturation, back-to-back frames");
    xs = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    send_frame(xs, 1'b0);
    check_output("sat_hi_y0", model_y(xs, 0), 511);
    xs = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    send_frame(xs, 1'b0);
    check_output("sat_lo_y0", model_y(xs, 0), -512);
    drain();

    $display("[TB] random frame, gap-free then with enb gaps");
    for (int k = 0; k < 8; k++) ra[k] = int'($urandom_range(4095)) - 2048;
    send_frame(ra, 1'b0);
    send_frame(ra, 1'b1);
    drain();

    $display("[TB] sync at in_cnt=4");
    for (int k = 0; k < 8; k++) ra[k] = int'($urandom_range(1023)) - 512;
    send_frame(ra, 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1500 - 300 * k, 1'b0, 1'b1);
      check_beat();
    end
    xs = '{512, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xs, 1'b0);
    drain();

    $display("[TB] reset at in_cnt=5");
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(700 + k, k == 0, 1'b1);
      check_beat();
    end
    rst = 1'b1;
    apply_stimulus(0, 1'b0, 1'b1);
    rst = 1'b0;
    check_output("mid_rst_out", int'(idct_out), 0);
    check_output("mid_rst_valid", int'(idct_valid), 0);
    check_output("mid_rst_sof", int'(idct_sof), 0);
    exp_q.delete();
    exp_valid   = 1'b0;
    last_popped = 1'b0;
    xs = '{256, 0, 0, 0, 0, 0, 0, 0};
    send_frame(xs, 1'b0);
    drain();

    enb = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idct_1d_serial.md
Name: idct_1d_serial

Overview:
- 8-point 1-D inverse DCT, serial in / serial out. Inverse counterpart of the forward 1-D DCT stage in the JPEG-DCT pipeline.
- Accepts one coefficient per enabled clock in order X[0]..X[7] and emits reconstructed samples y[0]..y[7] one per enabled clock, one frame later.
- Two instances with the existing transpose memory between them form the 2-D IDCT. idct_valid drives that memory's enable.

Parameters:
BWi, 12, input coefficient width (signed; equals forward DCT output width)
BWo, 10, output sample width (signed)
CW, 9, coefficient constant width (signed, 8 fractional bits)
ACCW, BWi+12, accumulator width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
enb  input  1  beat enable; all state advances only when high
sync  input  1  frame restart; sampled only with enb
idct_in  input  BWi  signed coefficient X[k], k = current input index
idct_out  output  BWo  signed reconstructed sample y[n]
idct_valid  output  1  high once the first full frame has been output-loaded
idct_sof  output  1  high while idct_out carries y[0]

Behaviour:
- Constants: C[n][k] = round-half-away-from-zero(128 * a_k * cos((2n+1)kπ/16)), with a_0 = 1/√2 and a_k = 1 otherwise.
  - Example magnitudes: 91, 126, 118, 106, 71, 49, 25.
- Input counter in_cnt (3 b):
  - on an enb beat, in_cnt <= in_cnt + 1, wrapping 7->0;
  - if sync=1 on an enb beat, the current beat is taken as k=0 and in_cnt <= 1.
- MAC bank: 8 accumulators acc[n] (ACCW, signed). On each enb beat with index k:
  - k=0: acc[n] <= C[n][0] * X;
  - otherwise: acc[n] <= acc[n] + C[n][k] * X.
- Frame close: on the k=7 beat, out_bank[n] <= sat_BWo((acc[n] + C[n][7] * X + 128) >>> 8) on the same edge.
  - Arithmetic shift; saturate to [-2^(BWo-1), 2^(BWo-1)-1].
- Output counter out_cnt (3 b):
  - cleared on the frame-close edge;
  - otherwise increments, with wrap, on each enb beat.
  - idct_out = out_bank[out_cnt] (combinational from registers).
- Latency and cadence:
  - y[0] is presented the cycle after the X[7] beat.
  - y[n] follows on successive enb beats; continuous streaming overlaps frame f output with frame f+1 input.
- idct_valid: set on the first frame-close edge; stays high until rst.
- idct_sof = idct_valid & (out_cnt == 0).
- enb low: no register changes; outputs hold.
- sync mid-frame: partial accumulation is discarded (the k=0 load overwrites acc); out_bank keeps the last completed frame.
- sync on a beat where in_cnt==0: behaves as a normal k=0 beat.
- Reset values (on rst, regardless of enb or sync):
  - in_cnt = 0, out_cnt = 0, acc = 0, out_bank = 0;
  - idct_out = 0, idct_valid = 0, idct_sof = 0.
- Reset mid-frame: the partial frame is lost; the first beat after reset is k=0.

Decomposition:
- Shared package idct_pkg: BW defaults, fractional shift (8), rounding offset (128), constant table C[8][8] as localparam function/array.
- Single sub-module idct_mac_lane (one accumulator, one constant-row mux, round/saturate), instanced 8 times.
- Top level holds the counters, sync handling and output mux.

Test Plan:
- rst, then X = {256, 0, 0, 0, 0, 0, 0, 0} -> all y[n] = 91; idct_valid rises the cycle after the X[7] beat; idct_sof high with y[0].
- X = {0, 256, 0, 0, 0, 0, 0, 0} -> y = {126, 106, 71, 25, -25, -71, -106, -126}.
- Saturation:
  - all X = 2047 -> y[0] = 511;
  - all X = -2048 -> y[0] = -512;
  - no wrap-around on any lane.
- enb toggled 50% during a frame -> identical outputs to the gap-free run; outputs hold during enb=0.
- sync asserted at in_cnt=4 with a new DC-only frame (X[0] = 512) -> y all 182; the prior partial frame never appears.
- rst asserted at in_cnt=5 -> all outputs 0 next cycle; idct_valid low until the next full frame closes.
